// File: rtl/tqvp_spi_pkg.sv
// tqvp_spi_pkg: register map, STATUS bit positions and FSM states for the SPI FIFO master.
package tqvp_spi_pkg;
    localparam logic [5:0] ADDR_DATA   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h04;
    localparam logic [5:0] ADDR_CTRL   = 6'h08;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_OVF   = 6;
    localparam int ST_DONE     = 7;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LEAD, S_TRAIL, S_END, S_HOLD} state_t;
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: first-word-fall-through synchronous FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = r_count == '0;
    assign full   = r_count == (AW+1)'(DEPTH);
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/tqvp_spi_fifo_master.sv
// tqvp_spi_fifo_master: TinyQV peripheral, mode-0/2 SPI master with TX/RX byte FIFOs,
// programmable SCLK divider, automatic CS framing and a level interrupt.
module tqvp_spi_fifo_master
    import tqvp_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int CTRL_W = DIV_W + 3;

    state_t            r_state;
    state_t            w_next;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  r_h;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [7:0]        r_rx;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_tx_ovf;
    logic              r_rx_ovf;
    logic              r_done;
    logic              r_irq;

    logic              w_wr, w_rd, w_tick, w_cpol, w_ie_done, w_ie_rx, w_st_wr;
    logic              w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [7:0]        w_tx_dout, w_rx_dout;
    logic              w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CW-1:0]     w_tx_count, w_rx_count;
    logic [31:0]       w_status;
    logic              w_unused;

    assign w_wr       = data_write_n != 2'b11;
    assign w_rd       = data_read_n != 2'b11;
    assign w_st_wr    = w_wr && address == ADDR_STATUS;
    assign w_tx_push  = w_wr && address == ADDR_DATA;
    assign w_rx_pop   = w_rd && address == ADDR_DATA;
    assign w_tx_pop   = (r_state == S_IDLE || r_state == S_END) && !w_tx_empty;
    assign w_rx_push  = r_state == S_END;
    assign w_tick     = r_cnt == r_h;
    assign w_cpol     = r_ctrl[DIV_W];
    assign w_ie_done  = r_ctrl[DIV_W+1];
    assign w_ie_rx    = r_ctrl[DIV_W+2];
    assign w_unused   = ^{ui_in[7:3], ui_in[1:0], data_in[31:CTRL_W]};

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .rst(rst), .push(w_tx_push), .pop(w_tx_pop), .din(data_in[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    spi_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop), .din(r_rx),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_tx_empty) w_next = S_SETUP;
            S_SETUP: if (w_tick) w_next = S_LEAD;
            S_LEAD:  if (w_tick) w_next = S_TRAIL;
            S_TRAIL: if (w_tick) w_next = (r_bit == 3'd7) ? S_END : S_LEAD;
            S_END:   w_next = w_tx_empty ? S_HOLD : S_LEAD;
            S_HOLD:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The divider value is latched on every state entry, so CTRL edits land on the next half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_h      <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_rx     <= '0;
            r_ctrl   <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
                r_h   <= r_ctrl[DIV_W-1:0];
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
            end
            if (w_tx_pop) begin
                r_shift <= w_tx_dout;
                r_bit   <= '0;
            end else if (r_state == S_LEAD && w_tick) begin
                r_shift <= {r_shift[6:0], 1'b0};
            end else if (r_state == S_TRAIL && w_tick) begin
                r_bit <= r_bit + 3'd1;
            end
            if (w_next == S_LEAD && r_state != S_LEAD) r_rx <= {r_rx[6:0], ui_in[2]};
            if (w_wr && address == ADDR_CTRL) r_ctrl <= data_in[CTRL_W-1:0];
            r_tx_ovf <= (w_tx_push && w_tx_full && !w_tx_pop) || (r_tx_ovf && !(w_st_wr && data_in[ST_TX_OVF]));
            r_rx_ovf <= (w_rx_push && w_rx_full && !w_rx_pop) || (r_rx_ovf && !(w_st_wr && data_in[ST_RX_OVF]));
            r_done   <= (r_state == S_HOLD && w_tick) || (r_done && !(w_st_wr && data_in[ST_DONE]));
            r_irq    <= (w_ie_done && r_done) || (w_ie_rx && !w_rx_empty);
        end
    end

    assign w_status = {16'h0, 4'(w_rx_count), 4'(w_tx_count), r_done, r_rx_ovf, r_tx_ovf,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full, r_state != S_IDLE};

    assign data_out = (address == ADDR_DATA)   ? {24'h0, w_rx_empty ? 8'h00 : w_rx_dout} :
                      (address == ADDR_STATUS) ? w_status :
                      (address == ADDR_CTRL)   ? 32'(r_ctrl) : 32'h0;

    assign data_ready     = w_rd;
    assign user_interrupt = r_irq;
    assign uo_out = {2'b00, r_shift[7], (r_state == S_LEAD) ? ~w_cpol : w_cpol, r_state == S_IDLE, 3'b000};
endmodule

// File: tb/tb_tqvp_spi_fifo_master.sv
// tb_tqvp_spi_fifo_master: register-map vector table plus directed SPI transfer sequences.
module tb_tqvp_spi_fifo_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    logic loopback = 1'b0;
    logic miso_fix = 1'b0;
    assign ui_in = {5'b0, loopback ? uo_out[5] : miso_fix, 2'b0};

    always #5 clk = ~clk;

    tqvp_spi_fifo_master dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic last_rdy;

    bit mosi_q[$];
    int edge_t[$];
    int cs_rise = 0;
    int cyc = 0;
    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;

    // Records MOSI at each SCLK rising edge and counts CS_n deassertions
    always @(posedge clk) begin
        #1;
        cyc++;
        if (uo_out[4] && !prev_sclk) begin
            mosi_q.push_back(uo_out[5]);
            edge_t.push_back(cyc);
        end
        if (uo_out[3] && !prev_cs) cs_rise++;
        prev_sclk = uo_out[4];
        prev_cs = uo_out[3];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        data_write_n = 2'b00;
        @(posedge clk);
        #1;
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        data_read_n = 2'b10;
        #1;
        d = data_out;
        last_rdy = data_ready;
        @(posedge clk);
        #1;
        data_read_n = 2'b11;
    endtask

    task automatic wait_idle(input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            address = 6'h04;
            #1;
            if (!data_out[0] && data_out[2]) break;
        end
        n_cmp++;
        if (i == max) begin
            n_bad++;
            $display("FAIL %s: still busy after %0d cycles", name, max);
        end
    endtask

    task automatic clear_mon();
        mosi_q.delete();
        edge_t.delete();
        cs_rise = 0;
    endtask

    function automatic logic [31:0] packed_mosi(input int n);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < n && i < mosi_q.size(); i++) v = {v[30:0], mosi_q[i]};
        return v;
    endfunction

    typedef struct {
        logic [5:0]  a;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_uo;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] d;
        int i;
        vt[0] = '{6'h04, 1'b0, 32'h0,        32'h0000_0014, 8'h08};
        vt[1] = '{6'h08, 1'b0, 32'h0,        32'h0000_0000, 8'h08};
        vt[2] = '{6'h00, 1'b0, 32'h0,        32'h0000_0000, 8'h08};
        vt[3] = '{6'h0C, 1'b0, 32'h0,        32'h0000_0000, 8'h08};
        vt[4] = '{6'h08, 1'b1, 32'hFFFF_FFFF, 32'h0000_07FF, 8'h18};
        vt[5] = '{6'h08, 1'b1, 32'h0000_0105, 32'h0000_0105, 8'h18};
        vt[6] = '{6'h0C, 1'b1, 32'h0000_FFFF, 32'h0000_0000, 8'h18};
        vt[7] = '{6'h04, 1'b1, 32'h0000_00FF, 32'h0000_0014, 8'h18};
        vt[8] = '{6'h08, 1'b1, 32'h0000_0000, 32'h0000_0000, 8'h08};
        vt[9] = '{6'h3C, 1'b0, 32'h0,        32'h0000_0000, 8'h08};

        repeat (3) @(negedge clk);
        #1;
        check("reset_uo", {24'h0, uo_out}, 32'h08);
        check("reset_data_out", data_out, 32'h0);
        check("reset_irq", {31'h0, user_interrupt}, 32'h0);
        check("reset_ready", {31'h0, data_ready}, 32'h0);
        rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            if (vt[k].wr) wr(vt[k].a, vt[k].wd);
            rd(vt[k].a, d);
            check($sformatf("vec%0d_rd", k), d, vt[k].exp_rd);
            check($sformatf("vec%0d_ready", k), {31'h0, last_rdy}, 32'h1);
            #1;
            check($sformatf("vec%0d_uo", k), {24'h0, uo_out}, {24'h0, vt[k].exp_uo});
        end

        // Single byte, DIV=0, MISO high
        miso_fix = 1'b1;
        clear_mon();
        wr(6'h00, 32'hA5);
        wait_idle(200, "t1_idle");
        check("t1_edges", mosi_q.size(), 8);
        check("t1_mosi", packed_mosi(8), 32'hA5);
        check("t1_period", (edge_t.size() >= 2) ? edge_t[1] - edge_t[0] : 0, 2);
        check("t1_period_last", (edge_t.size() >= 8) ? edge_t[7] - edge_t[6] : 0, 2);
        rd(6'h04, d);
        check("t1_status", d, 32'h0000_1084);
        rd(6'h00, d);
        check("t1_rx", d, 32'hFF);
        rd(6'h00, d);
        check("t1_rx_empty", d, 32'h0);
        wr(6'h04, 32'h80);
        rd(6'h04, d);
        check("t1_done_clr", d, 32'h14);

        // Back-to-back bytes, DIV=3, MOSI looped to MISO
        loopback = 1'b1;
        wr(6'h08, 32'h3);
        clear_mon();
        wr(6'h00, 32'h01);
        wr(6'h00, 32'h02);
        wr(6'h00, 32'h03);
        wait_idle(1000, "t2_idle");
        check("t2_edges", mosi_q.size(), 24);
        check("t2_mosi", packed_mosi(24), 32'h0001_0203);
        check("t2_cs_rise", cs_rise, 1);
        check("t2_period", (edge_t.size() >= 2) ? edge_t[1] - edge_t[0] : 0, 8);
        rd(6'h04, d);
        check("t2_rx_count", (d >> 12) & 32'hF, 3);
        rd(6'h00, d);
        check("t2_rx0", d, 32'h01);
        rd(6'h00, d);
        check("t2_rx1", d, 32'h02);
        rd(6'h00, d);
        check("t2_rx2", d, 32'h03);

        // Stalled SPI fills TX, then overflow
        wr(6'h04, 32'hE0);
        wr(6'h08, 32'hFF);
        for (int k = 1; k <= 5; k++) wr(6'h00, 32'(k));
        rd(6'h04, d);
        check("t3_full", d, 32'h0000_0413);
        wr(6'h00, 32'h06);
        rd(6'h04, d);
        check("t3_ovf", d, 32'h0000_0433);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(6'h04, d);
        check("t3_after_rst", d, 32'h14);

        // RX overflow on the fifth byte
        clear_mon();
        for (int k = 1; k <= 5; k++) wr(6'h00, 32'h11 * k);
        wait_idle(500, "t4_idle");
        rd(6'h04, d);
        check("t4_status", d, 32'h0000_40CC);
        for (int k = 1; k <= 4; k++) begin
            rd(6'h00, d);
            check($sformatf("t4_rx%0d", k), d, 32'h11 * k);
        end
        rd(6'h00, d);
        check("t4_rx_empty", d, 32'h0);

        // RX interrupt latency, then DONE interrupt
        wr(6'h04, 32'hE0);
        wr(6'h08, 32'h400);
        wr(6'h00, 32'h5A);
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            address = 6'h04;
            #1;
            if (!data_out[4]) break;
        end
        check("t5_rx_push_seen", (i < 200) ? 32'h1 : 32'h0, 32'h1);
        check("t5_irq_lag", {31'h0, user_interrupt}, 32'h0);
        @(negedge clk);
        #1;
        check("t5_irq_rise", {31'h0, user_interrupt}, 32'h1);
        rd(6'h00, d);
        check("t5_rx", d, 32'h5A);
        @(negedge clk);
        #1;
        check("t5_irq_hold", {31'h0, user_interrupt}, 32'h1);
        @(negedge clk);
        #1;
        check("t5_irq_fall", {31'h0, user_interrupt}, 32'h0);
        wait_idle(200, "t5_idle");
        wr(6'h08, 32'h200);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_done_irq", {31'h0, user_interrupt}, 32'h1);
        wr(6'h04, 32'h80);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t5_done_irq_clr", {31'h0, user_interrupt}, 32'h0);

        // Reset in the middle of a byte
        wr(6'h08, 32'h3);
        clear_mon();
        wr(6'h00, 32'hC3);
        for (i = 0; i < 400 && edge_t.size() < 4; i++) @(negedge clk);
        check("t6_reached_bit4", (edge_t.size() >= 4) ? 32'h1 : 32'h0, 32'h1);
        @(negedge clk);
        check("t6_cs_low", {31'h0, uo_out[3]}, 32'h0);
        rst = 1'b1;
        address = 6'h04;
        #1;
        check("t6_uo", {24'h0, uo_out}, 32'h08);
        check("t6_status", data_out, 32'h14);
        @(negedge clk);
        rst = 1'b0;
        rd(6'h08, d);
        check("t6_ctrl", d, 32'h0);
        rd(6'h00, d);
        check("t6_no_rx", d, 32'h0);
        repeat (5) @(negedge clk);
        #1;
        check("t6_uo_stays", {24'h0, uo_out}, 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
